// File: rtl/tx_osr_pkg.sv
// tx_osr_pkg: shared widths, count decode and stall reason codes for the TX/OSR path.
package tx_osr_pkg;
    localparam int OSR_W = 32;

    typedef enum logic [1:0] {
        STALL_NONE,
        STALL_EMPTY,
        STALL_REFILL
    } stall_e;

    // 5-bit bit counts encode 32 as 0.
    function automatic logic [5:0] decode_count(input logic [4:0] c);
        return (c == 5'd0) ? 6'd32 : {1'b0, c};
    endfunction
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: DEPTH x 32 circular TX buffer; pops on empty are ignored, pushes on full refused.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wdata,
    input  logic             wvalid,
    output logic             wready,
    input  logic             pop,
    output logic [31:0]      rdata,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign wready  = level != LVL_W'(DEPTH);
    assign empty   = level == '0;
    assign do_push = wvalid && wready;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/tx_osr.sv
// tx_osr: TX FIFO plus output shift register serving PULL/OUT with optional autopull.
module tx_osr
    import tx_osr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      fifo_wdata,
    input  logic             fifo_wvalid,
    output logic             fifo_wready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             fifo_empty,
    input  logic             shift_right,
    input  logic             autopull_en,
    input  logic [4:0]       pull_thresh,
    input  logic             pull_req,
    input  logic             pull_block,
    input  logic [31:0]      pull_fallback,
    input  logic             out_req,
    input  logic [4:0]       out_count,
    output logic [31:0]      out_data,
    output logic             stall,
    output logic [5:0]       osr_count
);
    logic [OSR_W-1:0] osr;
    logic [OSR_W-1:0] head;
    logic [OSR_W-1:0] load_val;
    logic [5:0]       n;
    logic [5:0]       thr;
    logic [6:0]       sum;
    logic             ap_need;
    logic             pop;
    logic             load;
    logic             do_out;
    stall_e           reason;

    tx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wdata  (fifo_wdata),
        .wvalid (fifo_wvalid),
        .wready (fifo_wready),
        .pop    (pop),
        .rdata  (head),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_comb begin
        n        = decode_count(out_count);
        thr      = decode_count(pull_thresh);
        ap_need  = autopull_en && osr_count >= thr;
        pop      = 1'b0;
        load     = 1'b0;
        load_val = head;
        do_out   = 1'b0;
        reason   = STALL_NONE;
        if (pull_req) begin
            // With autopull on, a PULL below threshold is a no-op.
            if (!autopull_en || ap_need) begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else if (pull_block) begin
                    reason = STALL_EMPTY;
                end else begin
                    load     = 1'b1;
                    load_val = pull_fallback;
                end
            end
            if (out_req) reason = STALL_REFILL;
        end else if (out_req) begin
            if (ap_need) begin
                reason = fifo_empty ? STALL_EMPTY : STALL_REFILL;
                pop    = !fifo_empty;
                load   = !fifo_empty;
            end else begin
                do_out = 1'b1;
            end
        end else if (ap_need && !fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
        end
    end

    assign sum      = {1'b0, osr_count} + {1'b0, n};
    assign stall    = rst && reason != STALL_NONE;
    assign out_data = !(rst && do_out) ? '0 :
                      shift_right ? osr & ~(32'hFFFF_FFFF << n) : osr >> (6'd32 - n);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            osr       <= '0;
            osr_count <= 6'd32;
        end else if (load) begin
            osr       <= load_val;
            osr_count <= '0;
        end else if (do_out) begin
            osr       <= shift_right ? osr >> n : osr << n;
            osr_count <= (sum > 7'd32) ? 6'd32 : sum[5:0];
        end
    end
endmodule

// File: tb/tb_tx_osr.sv
// tb_tx_osr: table-driven directed vectors plus a reset-mid-stall sequence for tx_osr.
module tb_tx_osr;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_wdata;
    logic        fifo_wvalid;
    logic        fifo_wready;
    logic [2:0]  fifo_level;
    logic        fifo_empty;
    logic        shift_right;
    logic        autopull_en;
    logic [4:0]  pull_thresh;
    logic        pull_req;
    logic        pull_block;
    logic [31:0] pull_fallback;
    logic        out_req;
    logic [4:0]  out_count;
    logic [31:0] out_data;
    logic        stall;
    logic [5:0]  osr_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        push;
        logic [31:0] wdata;
        logic        sr;
        logic        ap;
        logic [4:0]  thr;
        logic        preq;
        logic        pblk;
        logic [31:0] fb;
        logic        oreq;
        logic [4:0]  ocnt;
        logic [31:0] eout;
        logic        estall;
        logic [5:0]  ecnt;
        logic [2:0]  elvl;
        logic        ewr;
    } vec_t;

    vec_t vecs[$];

    tx_osr #(.DEPTH(4), .LVL_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_wdata    (fifo_wdata),
        .fifo_wvalid   (fifo_wvalid),
        .fifo_wready   (fifo_wready),
        .fifo_level    (fifo_level),
        .fifo_empty    (fifo_empty),
        .shift_right   (shift_right),
        .autopull_en   (autopull_en),
        .pull_thresh   (pull_thresh),
        .pull_req      (pull_req),
        .pull_block    (pull_block),
        .pull_fallback (pull_fallback),
        .out_req       (out_req),
        .out_count     (out_count),
        .out_data      (out_data),
        .stall         (stall),
        .osr_count     (osr_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [31:0] p, wd, sr, ap, th, pr, pb, fb, orq, oc,
                       eo, es, ec, el, ew);
        vec_t v;
        v.push = p[0]; v.wdata = wd; v.sr = sr[0]; v.ap = ap[0]; v.thr = th[4:0];
        v.preq = pr[0]; v.pblk = pb[0]; v.fb = fb; v.oreq = orq[0]; v.ocnt = oc[4:0];
        v.eout = eo; v.estall = es[0]; v.ecnt = ec[5:0]; v.elvl = el[2:0]; v.ewr = ew[0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fifo_wvalid = 0; fifo_wdata = 0; shift_right = 0; autopull_en = 0; pull_thresh = 0;
        pull_req = 0; pull_block = 0; pull_fallback = 0; out_req = 0; out_count = 0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] eo, input logic es,
                             input logic [5:0] ec, input logic [2:0] el, input logic ew);
        chk({tag, ".out_data"}, out_data, eo);
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".osr_count"}, 32'(osr_count), 32'(ec));
        chk({tag, ".fifo_level"}, 32'(fifo_level), 32'(el));
        chk({tag, ".fifo_wready"}, 32'(fifo_wready), 32'(ew));
    endtask

    initial begin
        //   push wdata          sr ap th pr pb fb     or oc | eout          st cnt lvl wr
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(1, 32'hDEADBEEF,  0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 32, 1, 1);
        add(0, 0,             1, 0, 0, 0, 0, 0,     1, 8,   32'hEF,       0, 0,  0, 1);
        add(0, 0,             1, 0, 0, 0, 0, 0,     1, 0,   32'h00DEADBE, 0, 8,  0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(1, 32'h80000001,  0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 32, 1, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     1, 1,   1,            0, 0,  0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     1, 31,  1,            0, 1,  0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        // fill to full, then a push with a simultaneous pop must be refused
        add(1, 1,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(1, 2,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 1, 1);
        add(1, 3,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 2, 1);
        add(1, 4,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 3, 1);
        add(1, 5,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 32, 4, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 0,  3, 1);
        add(0, 0,             1, 0, 0, 0, 0, 0,     1, 0,   1,            0, 0,  3, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 32, 3, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 0,  2, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 0,  1, 1);
        add(0, 0,             1, 0, 0, 0, 0, 0,     1, 0,   4,            0, 0,  0, 1);
        // autopull: stall on empty, refill cycle, then OUT completes
        add(1, 32'hAAAA5555,  0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            0, 32, 1, 1);
        add(0, 0,             1, 1, 16, 0, 0, 0,    1, 16,  32'h5555,     0, 0,  0, 1);
        add(0, 0,             1, 1, 16, 0, 0, 0,    1, 4,   0,            1, 16, 0, 1);
        add(1, 32'h12345678,  1, 1, 16, 0, 0, 0,    1, 4,   0,            1, 16, 0, 1);
        add(0, 0,             1, 1, 16, 0, 0, 0,    1, 4,   0,            1, 16, 1, 1);
        add(0, 0,             1, 1, 16, 0, 0, 0,    1, 4,   8,            0, 0,  0, 1);
        add(0, 0,             0, 1, 16, 0, 0, 0,    0, 0,   0,            0, 4,  0, 1);
        // PULL below threshold is a no-op; background autopull once threshold drops
        add(1, 32'h11111111,  0, 1, 16, 0, 0, 0,    0, 0,   0,            0, 4,  0, 1);
        add(0, 0,             0, 1, 16, 1, 1, 0,    0, 0,   0,            0, 4,  1, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 4,  1, 1);
        add(0, 0,             0, 1, 4, 0, 0, 0,     0, 0,   0,            0, 4,  1, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 0,  0, 1);
        add(0, 0,             1, 0, 0, 0, 0, 0,     1, 0,   32'h11111111, 0, 0,  0, 1);
        // blocking pull stalls on empty; non-blocking loads the fallback
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            1, 32, 0, 1);
        add(0, 0,             0, 0, 0, 1, 1, 0,     0, 0,   0,            1, 32, 0, 1);
        add(0, 0,             0, 0, 0, 1, 0, 32'h1F, 0, 0,  0,            0, 32, 0, 1);
        add(0, 0,             1, 0, 0, 0, 0, 0,     1, 0,   32'h1F,       0, 0,  0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        // PULL and OUT together: pull happens, OUT ignored with stall
        add(1, 32'h77,        0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 32, 0, 1);
        add(0, 0,             1, 0, 0, 1, 1, 0,     1, 0,   0,            1, 32, 1, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0,     0, 0,   0,            0, 0,  0, 1);

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 32, 0, 1);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            fifo_wvalid = vecs[i].push; fifo_wdata = vecs[i].wdata;
            shift_right = vecs[i].sr; autopull_en = vecs[i].ap; pull_thresh = vecs[i].thr;
            pull_req = vecs[i].preq; pull_block = vecs[i].pblk; pull_fallback = vecs[i].fb;
            out_req = vecs[i].oreq; out_count = vecs[i].ocnt;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].eout, vecs[i].estall, vecs[i].ecnt,
                      vecs[i].elvl, vecs[i].ewr);
        end

        // hold a blocking pull on empty, then drop reset mid-cycle
        @(negedge clk);
        idle_inputs();
        pull_req = 1; pull_block = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_all($sformatf("hold%0d", k), 0, 1, 0, 0, 1);
            @(negedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        check_all("rst_mid", 0, 0, 32, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        out_req = 1; shift_right = 1;
        #1;
        check_all("post_rst", 0, 0, 32, 0, 1);
        @(negedge clk);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_osr.md
Name: tx_osr

Overview:
- TX path feeding the state machine's OUT and PULL instructions.
- System side pushes 32-bit words into a small TX FIFO. The state machine drains them into a 32-bit output shift register (OSR), by explicit PULL or by autopull.
- OUT shifts 1-32 bits from the OSR to the executing stage each cycle.
- Sits directly upstream of the state machine FSM, alongside the instruction memory.

Parameters:
- DEPTH, 4, TX FIFO depth in words (power of two, ≥2).
- LVL_W, 3, width of fifo_level (must hold 0..DEPTH).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- fifo_wdata  in  32  word pushed by system side.
- fifo_wvalid  in  1  push request.
- fifo_wready  out  1  high when FIFO not full; a push occurs when wvalid&wready.
- fifo_level  out  LVL_W  current FIFO occupancy.
- fifo_empty  out  1  level==0.
- shift_right  in  1  1: OUT takes LSBs and OSR shifts right; 0: takes MSBs and OSR shifts left.
- autopull_en  in  1  enable autopull.
- pull_thresh  in  5  autopull threshold in bits; 0 means 32.
- pull_req  in  1  PULL instruction executing this cycle.
- pull_block  in  1  PULL blocks when FIFO empty.
- pull_fallback  in  32  value loaded by non-blocking PULL on empty FIFO (the X scratch register).
- out_req  in  1  OUT instruction executing this cycle.
- out_count  in  5  bits to shift; 0 means 32.
- out_data  out  32  shifted-out bits, zero-extended, valid in the out_req cycle.
- stall  out  1  current PULL/OUT did not complete; the FSM holds pc and re-issues.
- osr_count  out  6  bits consumed from OSR, 0..32; 32 = OSR empty.

Behaviour:
Reset (rst low, async):
- FIFO empty, pointers 0; OSR=0; osr_count=32.
- fifo_wready=1, stall=0, out_data=0.

FIFO:
- Circular buffer with read/write pointers plus level counter.
- Push and pop in the same cycle:
  - Level unchanged when both succeed.
  - Push when full is refused (wready=0) even if a pop occurs that cycle.
  - Pop when empty is never performed; no write-to-read bypass.
- Pointers wrap modulo DEPTH.

PULL (pull_req=1):
- FIFO non-empty: OSR←head, pop, osr_count←0, stall=0. Takes effect at the next edge.
- Empty and pull_block=1: stall=1, no state change.
- Empty and pull_block=0: OSR←pull_fallback, osr_count←0, stall=0.
- Autopull on and osr_count<thresh: PULL is a no-op with stall=0. This holds both when the FIFO is empty and when it is non-empty.

OUT (out_req=1, pull_req=0), with n = out_count (0→32):
- Autopull on and osr_count≥thr (thr = pull_thresh, 0→32):
  - FIFO non-empty: OSR←head, pop, osr_count←0, stall=1. The OUT completes on its re-issue one cycle later.
  - FIFO empty: stall=1, no change.
- Otherwise, out_data combinational:
  - Right: OSR[n-1:0] zero-extended; OSR←OSR>>n.
  - Left: OSR[31:32-n] in out_data[n-1:0]; OSR←OSR<<n.
  - Vacated bits are filled with 0. n=32 empties the OSR to 0.
  - osr_count←min(32, osr_count+n). Saturating; no wrap.
  - stall=0.
- out_data=0 whenever out_req=0 or stall=1.

Background autopull:
- Condition: pull_req=0, out_req=0, autopull_en=1, osr_count≥thr, FIFO non-empty.
- Action: OSR←head, pop, osr_count←0.

Other rules:
- pull_req and out_req both high: PULL processed, OUT ignored, stall=1.
- Threshold changes take effect combinationally on the next comparison.
- Reset mid-stall: all state returns to reset values; the FSM is reset by the same signal.

Decomposition:
- Shared package holds:
  - OSR_W=32.
  - The "0 encodes 32" count-decode helper, reused by the FSM's OUT/IN decode.
  - Stall reason constants (STALL_NONE, STALL_EMPTY, STALL_REFILL) for debug.
- One sub-module: tx_fifo (parameterised DEPTH×32, wvalid/wready push, pop/empty/level). The OSR and autopull logic stays in tx_osr.

Test Plan:
- Reset → osr_count=32, fifo_level=0, wready=1. Push 0xDEADBEEF, then pull_req with pull_block=1 → next cycle osr_count=0, level=0, stall=0.
- OSR=0xDEADBEEF, shift_right=1, out_req with out_count=8 → out_data=0xEF, OSR=0x00DEADBE, osr_count=8. Then count=0 → out_data=0x00DEADBE, osr_count=32.
- shift_right=0, OSR=0x80000001, out_count=1 → out_data=1, OSR=0x00000002. Then out_count=31 → out_data=1, osr_count=32.
- Push 4 words → wready=0. A 5th push with simultaneous pop is refused → level=3 after.
- autopull_en=1, thresh=16, osr_count=16, FIFO empty, out_req → stall held every cycle. Push 0x12345678 → one refill cycle with stall=1, then OUT (count 4, right) returns 0x8, osr_count=4.
- Blocking pull on empty FIFO → stall=1 held. Non-blocking pull with pull_fallback=0x0000001F → OSR=0x1F, stall=0. rst low mid-stall → immediate reset values.
